gaussian_scale_scheduler: RTL and testbench

- Sequences the shared Gaussian filter stage through NUM_SCALES blur passes per octave frame.
- Pass 0 pulls pixels from the down-sampler FIFO; passes 1..NUM_SCALES-1 pull from the feedback image buffer.
- Drives the Gaussian input write strobe and the kernel/scale select, and waits out pipeline latency between passes.
- Reports per-pass and per-frame completion to the octave controller.

---
 rtl/gaussian_scale_scheduler.sv | 124 ++++++++++++
 tb/tb_gaussian_scale_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_scale_scheduler.sv
// Runs NUM_SCALES Gaussian blur passes per frame: pass 0 reads the down-sampler, later passes read the feedback buffer.
// Pixels reach the filter with zero added latency; gauss_full or a missing source valid stalls transfers and holds all counters.
module gaussian_scale_scheduler #(
  parameter int IMG_W        = 320,
  parameter int IMG_H        = 240,
  parameter int NUM_SCALES   = 5,
  parameter int DRAIN_CYCLES = 16,
  parameter int DATA_W       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          src_valid,
  input  logic [DATA_W-1:0]             src_din,
  output logic                          src_rd_en,
  input  logic                          fb_valid,
  input  logic [DATA_W-1:0]             fb_din,
  output logic                          fb_rd_en,
  input  logic                          gauss_full,
  output logic                          gauss_wr,
  output logic [DATA_W-1:0]             gauss_dout,
  output logic [$clog2(NUM_SCALES)-1:0] scale_sel,
  output logic                          busy,
  output logic                          pass_done,
  output logic                          frame_done
);

  localparam int PIX_N = IMG_W * IMG_H;
  localparam int PIX_W = $clog2(PIX_N);
  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
  localparam int SEL_W = $clog2(NUM_SCALES);

  localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(PIX_N - 1);
  localparam logic [SEL_W-1:0] PASS_LAST = SEL_W'(NUM_SCALES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       r_state;
  logic [PIX_W-1:0] r_pix_cnt;
  logic [SEL_W-1:0] r_pass_cnt;
  logic [DRN_W-1:0] r_drain_cnt;

  logic w_run;
  logic w_first_pass;
  logic w_sel_valid;
  logic w_xfer;
  logic w_last_pix;

  assign w_run        = (r_state == S_RUN);
  assign w_first_pass = (r_pass_cnt == '0);
  assign w_sel_valid  = w_first_pass ? src_valid : fb_valid;
  // abort suppresses the transfer outright, including a last-pixel one
  assign w_xfer       = w_run & ~abort & ~gauss_full & w_sel_valid;
  assign w_last_pix   = (r_pix_cnt == PIX_LAST);

  assign src_rd_en  = w_xfer & w_first_pass;
  assign fb_rd_en   = w_xfer & ~w_first_pass;
  assign gauss_wr   = w_xfer;
  assign gauss_dout = w_run ? (w_first_pass ? src_din : fb_din) : '0;
  assign scale_sel  = r_pass_cnt;
  assign busy       = (r_state != S_IDLE);
  assign pass_done  = (r_state == S_DRAIN) & (r_drain_cnt == DRN_W'(1)) & ~abort;
  assign frame_done = (r_state == S_DONE) & ~abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_pix_cnt   <= '0;
      r_pass_cnt  <= '0;
      r_drain_cnt <= '0;
    end else if (abort) begin
      r_state     <= S_IDLE;
      r_pix_cnt   <= '0;
      r_pass_cnt  <= '0;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_RUN;
            r_pix_cnt  <= '0;
            r_pass_cnt <= '0;
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            if (w_last_pix) begin
              r_state     <= S_DRAIN;
              r_pix_cnt   <= '0;
              r_drain_cnt <= DRN_W'(DRAIN_CYCLES);
            end else begin
              r_pix_cnt <= r_pix_cnt + PIX_W'(1);
            end
          end
        end
        S_DRAIN: begin
          r_drain_cnt <= r_drain_cnt - DRN_W'(1);
          if (r_drain_cnt == DRN_W'(1)) begin
            r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (r_pass_cnt == PASS_LAST) begin
            r_state <= S_DONE;
          end else begin
            r_pass_cnt <= r_pass_cnt + SEL_W'(1);
            r_state    <= S_RUN;
          end
        end
        S_DONE: begin
          r_pass_cnt <= '0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gaussian_scale_scheduler.sv
// Scoreboard bench: each frame pushes its expected pixel/scale stream; a monitor pops on every gauss_wr.
module tb_gaussian_scale_scheduler;
  localparam int W = 4, H = 2, S = 3, D = 2, DW = 8;
  localparam int N = W * H;
  localparam int M = 256;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic src_valid = 1'b0, fb_valid = 1'b0, gauss_full = 1'b0;
  logic [DW-1:0] src_din, fb_din, gauss_dout;
  logic src_rd_en, fb_rd_en, gauss_wr, busy, pass_done, frame_done;
  logic [1:0] scale_sel;

  logic [DW-1:0] src_mem [M];
  logic [DW-1:0] fb_mem  [M];
  logic [7:0] src_idx = 8'd0, fb_idx = 8'd0;

  assign src_din = src_mem[src_idx];
  assign fb_din  = fb_mem[fb_idx];

  typedef struct packed {
    logic [DW-1:0] pix;
    logic [1:0]    sc;
  } exp_t;
  exp_t exp_q[$];

  int n_tests = 0, n_fail = 0;
  logic s_src, s_fb, s_wr, s_pd, s_fd, s_busy;
  logic [1:0] s_sel;

  gaussian_scale_scheduler #(
    .IMG_W(W), .IMG_H(H), .NUM_SCALES(S), .DRAIN_CYCLES(D), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_valid(src_valid), .src_din(src_din), .src_rd_en(src_rd_en),
    .fb_valid(fb_valid), .fb_din(fb_din), .fb_rd_en(fb_rd_en),
    .gauss_full(gauss_full), .gauss_wr(gauss_wr), .gauss_dout(gauss_dout),
    .scale_sel(scale_sel), .busy(busy), .pass_done(pass_done), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: sample outputs at negedge, then model the FIFO pops at the edge.
  task automatic step();
    @(negedge clk);
    s_src = src_rd_en; s_fb = fb_rd_en; s_wr = gauss_wr;
    s_pd = pass_done;  s_fd = frame_done; s_busy = busy; s_sel = scale_sel;
    @(posedge clk); #1;
    if (s_src) src_idx = src_idx + 8'd1;
    if (s_fb)  fb_idx  = fb_idx + 8'd1;
  endtask

  // A frame consumes N pixels from src for scale 0, then N per later scale from fb, in FIFO order.
  task automatic push_frame();
    exp_t e;
    logic [7:0] a;
    for (int i = 0; i < N; i++) begin
      a = src_idx + 8'(i);
      e.pix = src_mem[a]; e.sc = 2'd0;
      exp_q.push_back(e);
    end
    for (int p = 1; p < S; p++) begin
      for (int i = 0; i < N; i++) begin
        a = fb_idx + 8'((p - 1) * N + i);
        e.pix = fb_mem[a]; e.sc = 2'(p);
        exp_q.push_back(e);
      end
    end
  endtask

  // mode: 0 free-flow, 1 random, 2 backpressure, 3 source gating, 4 abort, 5 async reset
  task automatic run_frame(input int mode, output int lat);
    int wr, pd, hold;
    bit done, fired, resume, cut;
    wr = 0; pd = 0; hold = 0; done = 0; fired = 0; resume = 0; cut = 0; lat = -1;
    src_valid = 1'b1; fb_valid = 1'b1; gauss_full = 1'b0;
    push_frame();
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      src_valid = 1'b1; fb_valid = 1'b1; gauss_full = 1'b0;
      if (mode == 1) begin
        src_valid  = ($urandom_range(0, 3) != 0);
        fb_valid   = ($urandom_range(0, 3) != 0);
        gauss_full = ($urandom_range(0, 3) == 0);
      end
      if (!fired && ((mode == 2 && wr == 5) || (mode == 3 && wr == 10))) begin
        hold = (mode == 2) ? 3 : 4;
        fired = 1;
      end
      if (hold > 0) begin
        if (mode == 2) gauss_full = 1'b1;
        else begin src_valid = 1'b1; fb_valid = 1'b0; end
      end
      if (mode == 4 && wr == 15 && !fired) begin abort = 1'b1; fired = 1; end
      step();
      if (s_wr) wr++;
      if (s_pd) pd++;
      if (c == 0) check("busy_in_run", int'(s_busy), 1);
      if (resume) begin check("gate_resume_fb_rd", int'(s_fb), 1); resume = 0; end
      if (hold > 0) begin
        check("stall_no_wr", int'(s_wr), 0);
        check("stall_no_rd", int'(s_src | s_fb), 0);
        hold--;
        if (hold == 0 && mode == 3) resume = 1;
      end
      if (abort) begin
        check("abort_wr_suppressed", int'(s_wr), 0);
        check("abort_no_pulse", int'(s_pd | s_fd), 0);
        abort = 1'b0;
        step();
        check("abort_idle", int'(s_busy), 0);
        check("abort_sel_cleared", int'(s_sel), 0);
        check("abort_no_pulse_after", int'(s_pd | s_fd), 0);
        exp_q.delete();
        cut = 1; done = 1;
      end
      if (mode == 5 && wr == 2 * N && !done) begin
        #2; rst = 1'b0; #1;
        check("arst_busy", int'(busy), 0);
        check("arst_sel", int'(scale_sel), 0);
        check("arst_strobes", int'(gauss_wr | src_rd_en | fb_rd_en | pass_done), 0);
        @(posedge clk); #1;
        check("arst_hold_busy", int'(busy), 0);
        rst = 1'b1;
        exp_q.delete();
        cut = 1; done = 1;
      end
      if (s_fd && !done) begin lat = c; done = 1; end
    end
    if (!cut) begin
      check("frame_done_seen", int'(done), 1);
      check("pass_done_count", pd, S);
      check("write_count", wr, S * N);
      step();
      check("busy_falls", int'(s_busy), 0);
      check("queue_empty", exp_q.size(), 0);
    end
  endtask

  initial begin : monitor
    int cyc, wr_cnt, last_wr;
    exp_t e;
    cyc = 0; wr_cnt = 0; last_wr = -100;
    forever begin
      @(negedge clk);
      cyc++;
      check("pass_done_timing", int'(pass_done),
            int'(wr_cnt != 0 && wr_cnt % N == 0 && cyc == last_wr + D));
      check("frame_done_timing", int'(frame_done),
            int'(wr_cnt == S * N && cyc == last_wr + D + 2));
      if (gauss_wr) begin
        check("wr_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("dout", int'(gauss_dout), int'(e.pix));
          check("scale_sel", int'(scale_sel), int'(e.sc));
          check("src_rd_en", int'(src_rd_en), int'(e.sc == 2'd0));
          check("fb_rd_en", int'(fb_rd_en), int'(e.sc != 2'd0));
          check("wr_legal", int'(!gauss_full && (e.sc == 2'd0 ? src_valid : fb_valid)), 1);
        end
        wr_cnt++;
        last_wr = cyc;
      end else begin
        check("no_rd_without_wr", int'(src_rd_en | fb_rd_en), 0);
      end
      if (!busy) wr_cnt = 0;
    end
  end

  initial begin : main
    int lat;
    for (int i = 0; i < M; i++) begin
      src_mem[i] = DW'($urandom);
      fb_mem[i]  = DW'($urandom);
    end
    #23;
    check("rst_busy", int'(busy), 0);
    check("rst_wr", int'(gauss_wr), 0);
    check("rst_rd", int'(src_rd_en | fb_rd_en), 0);
    check("rst_sel", int'(scale_sel), 0);
    check("rst_pulses", int'(pass_done | frame_done), 0);
    @(posedge clk); #1;
    rst = 1'b1; src_valid = 1'b1; fb_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("idle_rd", int'(s_src | s_fb), 0);
      check("idle_wr", int'(s_wr), 0);
      check("idle_busy", int'(s_busy), 0);
    end
    start = 1'b1; abort = 1'b1; step();
    start = 1'b0; abort = 1'b0; step();
    check("start_abort_stays_idle", int'(s_busy), 0);

    run_frame(0, lat);
    check("frame_latency", lat, S * (N + D + 1));
    run_frame(2, lat);
    run_frame(3, lat);
    run_frame(4, lat);
    run_frame(0, lat);
    check("restart_latency", lat, S * (N + D + 1));
    for (int f = 0; f < 4; f++) run_frame(1, lat);
    run_frame(5, lat);
    run_frame(0, lat);
    check("post_reset_latency", lat, S * (N + D + 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
